// File: rtl/a_frame_unpacker.sv
// a_frame_unpacker: receive side of the a_if vector stage.
// Captures whole frames in one cycle, removes the stage's +OFFSET and
// replays the elements one by one on a valid/ready stream. Frames are held
// in a two-slot buffer because the source cannot be stalled; any frame that
// finds no room is dropped and flagged on a sticky overflow bit.
// Optional: define A_UNPACK_DROP_CNT_EN to add a saturating 8-bit drop_count.
module a_frame_unpacker #(
  parameter int WIDTH    = 8,
  parameter int NUM_ELEM = 9,
  parameter int OFFSET   = 100
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      frame_valid,
  input  logic [NUM_ELEM*WIDTH-1:0] frame_data,
  output logic                      elem_valid,
  input  logic                      elem_ready,
  output logic [WIDTH-1:0]          elem_data,
  output logic [3:0]                elem_idx,
  output logic                      elem_last,
  output logic                      busy,
  output logic                      overflow
`ifdef A_UNPACK_DROP_CNT_EN
  ,
  output logic [7:0]                drop_count
`endif
);

  typedef enum logic {SL_EMPTY, SL_FULL} slot_t;
  typedef enum logic {S_IDLE, S_SEND} ser_t;

  logic [NUM_ELEM-1:0][WIDTH-1:0] r_mem [2];
  slot_t                          r_slot [2];
  ser_t                           r_state;
  logic                           r_wptr;
  logic                           r_rptr;
  logic [3:0]                     r_cnt;
  logic                           r_ovf;

  logic                           w_full;
  logic                           w_other_full;
  logic                           w_xfer;
  logic                           w_pop;
  logic                           w_cap;
  logic                           w_drop;
  logic [NUM_ELEM-1:0][WIDTH-1:0] w_sub;

  assign w_full       = (r_slot[0] == SL_FULL) && (r_slot[1] == SL_FULL);
  assign w_other_full = (r_slot[~r_rptr] == SL_FULL);
  assign w_xfer       = elem_valid && elem_ready;
  assign w_pop        = w_xfer && elem_last;
  // A full buffer still accepts a frame when the head frees its slot this cycle.
  assign w_cap        = frame_valid && (!w_full || w_pop);
  assign w_drop       = frame_valid && w_full && !w_pop;

  // Remove the stage offset per element at capture time (wraps mod 2^WIDTH).
  always_comb begin
    w_sub = '0;
    for (int k = 0; k < NUM_ELEM; k++)
      w_sub[k] = frame_data[k*WIDTH +: WIDTH] - WIDTH'(OFFSET);
  end

  // Slot storage and per-slot EMPTY/FULL state; push after pop so a freed
  // slot can be refilled in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        r_mem[s]  <= '0;
        r_slot[s] <= SL_EMPTY;
      end
    end else begin
      if (w_pop) r_slot[r_rptr] <= SL_EMPTY;
      if (w_cap) begin
        r_slot[r_wptr] <= SL_FULL;
        r_mem[r_wptr]  <= w_sub;
      end
    end
  end

  // Write/read pointers toggle once per captured/retired frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (w_cap) r_wptr <= ~r_wptr;
      if (w_pop) r_rptr <= ~r_rptr;
    end
  end

  // Serializer: element counter plus IDLE/SEND state tracking head occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      if (w_pop)       r_cnt <= 4'd0;
      else if (w_xfer) r_cnt <= r_cnt + 4'd1;
      if (w_cap)                        r_state <= S_SEND;
      else if (w_pop && !w_other_full)  r_state <= S_IDLE;
    end
  end

  // Sticky loss flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

`ifdef A_UNPACK_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating count of dropped frames.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               r_drop_cnt <= 8'd0;
    else if (w_drop && r_drop_cnt != 8'hFF)  r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_count = r_drop_cnt;
`endif

  // Outputs come only from registered state; nothing from frame_* reaches them.
  assign elem_valid = (r_state == S_SEND);
  assign elem_data  = elem_valid ? r_mem[r_rptr][r_cnt] : '0;
  assign elem_idx   = r_cnt;
  assign elem_last  = (r_cnt == 4'(NUM_ELEM - 1));
  assign busy       = (r_slot[0] == SL_FULL) || (r_slot[1] == SL_FULL);
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_a_frame_unpacker.sv
// Bench for a_frame_unpacker: directed scenarios plus random traffic, all
// checked against a queue-of-frames reference model.
module tb_a_frame_unpacker;
  localparam int W   = 8;
  localparam int N   = 9;
  localparam int OFS = 100;
  localparam int FW  = N * W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_valid = 1'b0;
  logic [FW-1:0] frame_data = '0;
  logic          elem_valid;
  logic          elem_ready = 1'b0;
  logic [W-1:0]  elem_data;
  logic [3:0]    elem_idx;
  logic          elem_last;
  logic          busy;
  logic          overflow;
`ifdef A_UNPACK_DROP_CNT_EN
  logic [7:0]    drop_count;
`endif

  a_frame_unpacker #(.WIDTH(W), .NUM_ELEM(N), .OFFSET(OFS)) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .elem_valid  (elem_valid),
    .elem_ready  (elem_ready),
    .elem_data   (elem_data),
    .elem_idx    (elem_idx),
    .elem_last   (elem_last),
    .busy        (busy),
    .overflow    (overflow)
`ifdef A_UNPACK_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of recovered frames (at most two), the index of
  // the next element of the head frame, and the loss bookkeeping.
  int mq[$][N];
  int m_cnt = 0;
  int m_ovf = 0;
  int m_dc  = 0;

  function automatic void m_reset();
    mq.delete();
    m_cnt = 0;
    m_ovf = 0;
    m_dc  = 0;
  endfunction

  task automatic compare();
    int ev, ed;
    ev = (mq.size() > 0) ? 1 : 0;
    ed = ev ? mq[0][m_cnt] : 0;
    chk("valid", 32'(elem_valid), 32'(ev));
    chk("data",  32'(elem_data),  32'(ed));
    chk("idx",   32'(elem_idx),   32'(m_cnt));
    chk("last",  32'(elem_last),  32'(m_cnt == N - 1));
    chk("busy",  32'(busy),       32'(ev));
    chk("ovf",   32'(overflow),   32'(m_ovf));
`ifdef A_UNPACK_DROP_CNT_EN
    chk("dropcnt", 32'(drop_count), 32'(m_dc));
`endif
  endtask

  // Apply one clock edge worth of inputs to the model.
  task automatic m_edge();
    int f[N];
    bit pop;
    pop = 0;
    if (mq.size() > 0 && elem_ready) begin
      if (m_cnt == N - 1) begin
        void'(mq.pop_front());
        m_cnt = 0;
        pop = 1;
      end else m_cnt++;
    end
    if (frame_valid) begin
      if (mq.size() < 2) begin
        for (int k = 0; k < N; k++)
          f[k] = (int'(frame_data[k*W +: W]) - OFS + 256) % 256;
        mq.push_back(f);
      end else begin
        m_ovf = 1;
        if (m_dc < 255) m_dc++;
      end
    end
  endtask

  // Drive one cycle: inputs set just after an edge, checked at negedge.
  task automatic step(input logic fv, input logic [FW-1:0] fd, input logic rdy);
    frame_valid = fv;
    frame_data  = fd;
    elem_ready  = rdy;
    @(negedge clock);
    compare();
    m_edge();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [FW-1:0] mkframe(input int base);
    logic [FW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = 8'(base + k);
    return v;
  endfunction

  function automatic logic [FW-1:0] rndframe();
    logic [FW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    frame_valid = 1'b0;
    elem_ready = 1'b0;
    m_reset();
    @(posedge clock);
    #1;
    @(negedge clock);
    compare();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [FW-1:0] wf;

  initial begin
    do_reset();

    // Single frame 100..108 -> 0..8, then idle.
    step(1'b1, mkframe(100), 1'b1);
    chk("single_v0", 32'(elem_valid), 32'd1);
    chk("single_d0", 32'(elem_data), 32'd0);
    for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1);
    chk("single_busy", 32'(busy), 32'd0);

    // Backpressure with ready pattern 1,0,0,1.
    step(1'b1, mkframe(150), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3));

    // Wrap values.
    wf = mkframe(0);
    wf[0*W +: W] = 8'h00;
    wf[1*W +: W] = 8'h63;
    wf[2*W +: W] = 8'h64;
    wf[3*W +: W] = 8'hFF;
    step(1'b1, wf, 1'b0);
    chk("wrap0", 32'(elem_data), 32'h9C);
    step(1'b0, '0, 1'b1);
    chk("wrap1", 32'(elem_data), 32'hFF);
    step(1'b0, '0, 1'b1);
    chk("wrap2", 32'(elem_data), 32'h00);
    step(1'b0, '0, 1'b1);
    chk("wrap3", 32'(elem_data), 32'h9B);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

    // Simultaneous pop/push on a full buffer.
    step(1'b1, mkframe(10), 1'b0);
    step(1'b1, mkframe(30), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    chk("pp_last", 32'(elem_last), 32'd1);
    step(1'b1, mkframe(50), 1'b1);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    chk("pp_busy", 32'(busy), 32'd0);

    // Overflow: three frames while stalled, third dropped.
    step(1'b1, mkframe(120), 1'b0);
    step(1'b1, mkframe(140), 1'b0);
    step(1'b1, mkframe(160), 1'b0);
    chk("ov_flag", 32'(overflow), 32'd1);
    chk("ov_head", 32'(elem_data), 32'd20);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

    // Reset mid-frame after idx 4 transfer.
    do_reset();
    step(1'b1, mkframe(100), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    chk("mid_idx", 32'(elem_idx), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(elem_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    m_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1'b1, mkframe(105), 1'b1);
    chk("fresh_idx", 32'(elem_idx), 32'd0);
    chk("fresh_d",   32'(elem_data), 32'd5);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 4) == 0, rndframe(), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 25; i++) step(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/a_frame_unpacker.md
Name: a_frame_unpacker

Overview:
- Receive-side counterpart of the a_if vector stage.
- Captures 9-element frames presented with a one-cycle valid qualifier and subtracts the stage's +OFFSET to recover the original values.
- Replays the recovered elements one at a time on a valid/ready stream for the scoreboard/sink side.
- Frame source has no backpressure, so the block holds frames in a 2-entry frame buffer and flags any loss.

Parameters:
- WIDTH, 8, bit width of each element
- NUM_ELEM, 9, elements per frame
- OFFSET, 100, constant removed from every element (mod 2^WIDTH)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- frame_valid  input  1  frame present this cycle; no ready, source never waits
- frame_data  input  NUM_ELEM*WIDTH  element k at bits [k*WIDTH +: WIDTH]
- elem_valid  output  1  elem_data/elem_idx/elem_last valid
- elem_ready  input  1  sink accepts current element
- elem_data  output  WIDTH  recovered element (frame element - OFFSET)
- elem_idx  output  4  index 0..NUM_ELEM-1 of current element
- elem_last  output  1  high when elem_idx == NUM_ELEM-1
- busy  output  1  at least one frame buffered
- overflow  output  1  sticky: a frame was dropped

Behaviour:
- Reset (async assert, sync release):
  - both buffer entries empty; write/read pointers 0; element counter 0; overflow 0.
  - Outputs: elem_valid 0, elem_data 0, elem_idx 0, elem_last 0, busy 0.
- Arithmetic: subtraction applied at capture: entry[k] = frame_data[k] - OFFSET, modulo 2^WIDTH. Wrap is exact: input 0x63 with OFFSET 100 yields 0xFF.
- Capture: on a rising edge with frame_valid=1 and buffer not full, all NUM_ELEM elements are written to the write entry in one cycle and the write pointer toggles.
- Output path:
  - elem_valid = head entry occupied.
  - elem_data = head[counter]; elem_idx = counter; elem_last = (counter == NUM_ELEM-1).
  - All are driven from registers/buffer, with no combinational path from frame_* inputs.
- Latency: frame captured at edge N; elem_valid=1 with idx 0 from cycle N+1.
- Handshake:
  - element transfers when elem_valid && elem_ready; counter increments.
  - elem_data/elem_idx stay stable while elem_valid=1 and elem_ready=0.
- Frame end: transfer with elem_last=1 frees the head, toggles the read pointer and clears the counter to 0. If the other entry is occupied, its element 0 is presented the next cycle (no bubble).
- State machine per frame slot (EMPTY, FULL) plus a serializer (IDLE when no head, SEND otherwise):
  - IDLE -> SEND on capture.
  - SEND -> IDLE on last transfer with the other slot empty and no capture that cycle.
- Full buffer (2 frames held) and frame_valid=1:
  - if the head's last element transfers the same cycle, the new frame is captured into the freed slot (simultaneous pop/push allowed);
  - otherwise the frame is dropped and overflow is set and stays 1 until reset.
  - A dropped frame never corrupts the buffered entries.
- Empty buffer, frame_valid=1, elem_ready=1: no transfer that cycle (elem_valid still 0).
- busy = any slot occupied.
- Reset asserted mid-frame: all outputs return to reset values immediately; partially sent frame discarded.

Optional Feature:
- Macro A_UNPACK_DROP_CNT_EN.
- Defined:
  - adds output drop_count, 8 bits, reset 0.
  - increments on each dropped frame; saturates at 255.
  - overflow behaves as specified.
- Undefined: port and counter absent; overflow is the only loss indication.

Test Plan:
- Single frame: frame_data elements 100..108, elem_ready=1 -> elem_valid from next cycle. Nine transfers, data 0..8, idx 0..8, elem_last only on idx 8. busy drops the cycle after.
- Backpressure: elem_ready toggling 1,0,0,1 -> each element held stable while stalled. No element skipped or duplicated; order 0..8 preserved.
- Wrap: elements 0x00, 0x63, 0x64, 0xFF -> outputs 0x9C, 0xFF, 0x00, 0x9B.
- Overflow: elem_ready=0 and three consecutive frames -> frames 1 and 2 buffered, frame 3 dropped. overflow=1 (drop_count=1 with macro). Releasing elem_ready yields frame 1 then frame 2 with no bubble between.
- Simultaneous pop/push: buffer full, frame_valid asserted on the cycle of the head's elem_last transfer -> new frame captured, overflow stays 0, three frames delivered in order.
- Reset mid-frame: assert reset after idx 4 transfer -> elem_valid, busy and overflow go 0 without waiting for a clock edge. A fresh frame after release starts at idx 0.
